// File: rtl/core1_sequencer.sv
`default_nettype none
// core1_sequencer: command/response front end for the Core1 GF(2^m) datapath.
// Drives select/A/B for CORE_LAT cycles per step; MULADD chains a LUT multiply into an XOR.
module core1_sequencer #(
  parameter int unsigned CORE_LAT = 1,
  parameter logic [2:0]  SQR      = 3'd1,
  parameter logic [2:0]  XOR      = 3'd2,
  parameter logic [2:0]  LUT      = 3'd3,
  parameter logic [2:0]  MASK     = 3'd4,
  parameter logic [2:0]  MULADD   = 3'd5
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic [2:0]   cmd_op,
  input  logic [255:0] cmd_a,
  input  logic [255:0] cmd_b,
  output logic [2:0]   core_sel,
  output logic [255:0] core_a,
  output logic [255:0] core_b,
  input  logic [127:0] core_c,
  input  logic [127:0] core_d,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [127:0] rsp_c,
  output logic [127:0] rsp_d,
  output logic         rsp_err
);

  typedef enum logic [1:0] {IDLE, EXEC1, EXEC2, RESP} state_t;

  localparam logic [3:0] LAST = 4'(CORE_LAT - 1);

  state_t         state_q, state_d;
  logic [3:0]     cnt_q, cnt_d;
  logic [2:0]     op_q, op_d;
  logic [127:0]   a_hi_q, a_hi_d;
  logic [127:0]   b_hi_q, b_hi_d;
  logic           cmd_ready_q, cmd_ready_d;
  logic [2:0]     core_sel_q, core_sel_d;
  logic [255:0]   core_a_q, core_a_d;
  logic [255:0]   core_b_q, core_b_d;
  logic           rsp_valid_q, rsp_valid_d;
  logic [127:0]   rsp_c_q, rsp_c_d;
  logic [127:0]   rsp_d_q, rsp_d_d;
  logic           rsp_err_q, rsp_err_d;
  logic           cmd_legal;

  assign cmd_legal = (cmd_op == SQR) || (cmd_op == XOR) || (cmd_op == LUT) ||
                     (cmd_op == MASK) || (cmd_op == MULADD);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    op_d        = op_q;
    a_hi_d      = a_hi_q;
    b_hi_d      = b_hi_q;
    cmd_ready_d = 1'b0;
    core_sel_d  = core_sel_q;
    core_a_d    = core_a_q;
    core_b_d    = core_b_q;
    rsp_valid_d = rsp_valid_q;
    rsp_c_d     = rsp_c_q;
    rsp_d_d     = rsp_d_q;
    rsp_err_d   = rsp_err_q;

    case (state_q)
      IDLE: begin
        cmd_ready_d = 1'b1;
        if (cmd_valid && cmd_ready_q) begin
          cmd_ready_d = 1'b0;
          op_d        = cmd_op;
          a_hi_d      = cmd_a[255:128];
          b_hi_d      = cmd_b[255:128];
          if (cmd_legal) begin
            // Core inputs are registered on the accept edge so they are live in cycle 1.
            state_d    = EXEC1;
            cnt_d      = 4'd0;
            core_sel_d = (cmd_op == MULADD) ? LUT : cmd_op;
            core_a_d   = cmd_a;
            core_b_d   = cmd_b;
          end else begin
            state_d     = RESP;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            rsp_c_d     = '0;
            rsp_d_d     = '0;
          end
        end
      end

      EXEC1: begin
        if (cnt_q == LAST) begin
          cnt_d = 4'd0;
          if (op_q == MULADD) begin
            state_d    = EXEC2;
            core_sel_d = XOR;
            core_a_d   = {core_c, core_d};
            core_b_d   = {a_hi_q, b_hi_q};
          end else begin
            state_d     = RESP;
            core_sel_d  = '0;
            core_a_d    = '0;
            core_b_d    = '0;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b0;
            rsp_c_d     = (op_q == MASK) ? 128'd0 : core_c;
            rsp_d_d     = (op_q == MASK) ? {64'd0, core_d[63:0]} : core_d;
          end
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end

      EXEC2: begin
        if (cnt_q == LAST) begin
          cnt_d       = 4'd0;
          state_d     = RESP;
          core_sel_d  = '0;
          core_a_d    = '0;
          core_b_d    = '0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b0;
          rsp_c_d     = core_c;
          rsp_d_d     = core_d;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end

      RESP: begin
        if (rsp_ready) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b0;
          cmd_ready_d = 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      op_q        <= 3'd0;
      a_hi_q      <= '0;
      b_hi_q      <= '0;
      cmd_ready_q <= 1'b0;
      core_sel_q  <= 3'd0;
      core_a_q    <= '0;
      core_b_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_c_q     <= '0;
      rsp_d_q     <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      op_q        <= op_d;
      a_hi_q      <= a_hi_d;
      b_hi_q      <= b_hi_d;
      cmd_ready_q <= cmd_ready_d;
      core_sel_q  <= core_sel_d;
      core_a_q    <= core_a_d;
      core_b_q    <= core_b_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_c_q     <= rsp_c_d;
      rsp_d_q     <= rsp_d_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign core_sel  = core_sel_q;
  assign core_a    = core_a_q;
  assign core_b    = core_b_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_c     = rsp_c_q;
  assign rsp_d     = rsp_d_q;
  assign rsp_err   = rsp_err_q;

endmodule
`default_nettype wire

// File: tb/tb_core1_sequencer.sv
`default_nettype none
// Bench for core1_sequencer: three instances (CORE_LAT 1/3/4) in front of a behavioural core,
// directed table vectors, hand-written reset/stall sequences and randomized commands vs a reference model.
module tb_core1_sequencer;

  logic clk;
  logic         rst_n     [3];
  logic         cmd_valid [3];
  logic         cmd_ready [3];
  logic [2:0]   cmd_op    [3];
  logic [255:0] cmd_a     [3];
  logic [255:0] cmd_b     [3];
  logic [2:0]   core_sel  [3];
  logic [255:0] core_a    [3];
  logic [255:0] core_b    [3];
  logic [127:0] core_c    [3];
  logic [127:0] core_d    [3];
  logic         rsp_valid [3];
  logic         rsp_ready [3];
  logic [127:0] rsp_c     [3];
  logic [127:0] rsp_d     [3];
  logic         rsp_err   [3];
  logic [255:0] noise;

  int n_checks = 0;
  int n_errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) noise <= {$urandom, $urandom, $urandom, $urandom,
                                  $urandom, $urandom, $urandom, $urandom};

  function automatic logic [127:0] clmul64(input logic [63:0] x, input logic [63:0] y);
    logic [127:0] r = '0;
    for (int i = 0; i < 64; i++) if (y[i]) r = r ^ ({64'd0, x} << i);
    return r;
  endfunction

  function automatic logic [127:0] spread64(input logic [63:0] x);
    logic [127:0] r = '0;
    for (int i = 0; i < 64; i++) r[2*i] = x[i];
    return r;
  endfunction

  // Behavioural Core1: combinational {C,D}; garbage when not selected.
  function automatic logic [255:0] core_fn(input logic [2:0] sel, input logic [255:0] a,
                                           input logic [255:0] b, input logic [255:0] nz);
    case (sel)
      3'd1:    return {spread64(b[127:64]), spread64(b[63:0])};
      3'd2:    return a ^ b;
      3'd3:    return {clmul64(a[127:64], b[127:64]), clmul64(a[63:0], b[63:0])};
      3'd4:    return {{128{1'b1}}, ~(a[127:0] & b[127:0])};
      default: return nz;
    endcase
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int L = (g == 0) ? 1 : ((g == 1) ? 3 : 4);
    core1_sequencer #(.CORE_LAT(L)) u_dut (
      .clk(clk), .rst_n(rst_n[g]),
      .cmd_valid(cmd_valid[g]), .cmd_ready(cmd_ready[g]), .cmd_op(cmd_op[g]),
      .cmd_a(cmd_a[g]), .cmd_b(cmd_b[g]),
      .core_sel(core_sel[g]), .core_a(core_a[g]), .core_b(core_b[g]),
      .core_c(core_c[g]), .core_d(core_d[g]),
      .rsp_valid(rsp_valid[g]), .rsp_ready(rsp_ready[g]),
      .rsp_c(rsp_c[g]), .rsp_d(rsp_d[g]), .rsp_err(rsp_err[g])
    );
    assign {core_c[g], core_d[g]} = core_fn(core_sel[g], core_a[g], core_b[g], noise);
  end

  function automatic int lat_of(input int idx);
    return (idx == 0) ? 1 : ((idx == 1) ? 3 : 4);
  endfunction

  function automatic bit is_legal(input logic [2:0] op);
    return (op >= 3'd1) && (op <= 3'd5);
  endfunction

  // Reference response {err, c, d} from the operation's meaning.
  function automatic logic [256:0] ref_rsp(input logic [2:0] op, input logic [255:0] a,
                                           input logic [255:0] b);
    logic [255:0] t;
    if (!is_legal(op)) return {1'b1, 256'd0};
    if (op == 3'd5) begin
      t = core_fn(3'd3, a, b, '0);
      return {1'b0, t ^ {a[255:128], b[255:128]}};
    end
    t = core_fn(op, a, b, '0);
    if (op == 3'd4) return {1'b0, 128'd0, 64'd0, t[63:0]};
    return {1'b0, t};
  endfunction

  function automatic int exp_lat(input logic [2:0] op, input int L);
    if (!is_legal(op)) return 1;
    return (op == 3'd5) ? 2 * L + 1 : L + 1;
  endfunction

  function automatic logic [2:0] exp_sel(input logic [2:0] op, input int k, input int L);
    if (!is_legal(op)) return 3'd0;
    if (k <= L) return (op == 3'd5) ? 3'd3 : op;
    if (op == 3'd5 && k <= 2 * L) return 3'd2;
    return 3'd0;
  endfunction

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic rand256(output logic [255:0] v);
    v = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
  endtask

  // One full command: accept, watch the core drive, check response, optional stall, handshake.
  task automatic run_cmd(input int idx, input logic [2:0] op, input logic [255:0] a,
                         input logic [255:0] b, input logic [256:0] exp, input int hold,
                         input bit early_ready, input string name);
    int L, cyc, w;
    bit sel_ok, ready_ok, stable_ok;
    logic [255:0] lut, r;
    logic [127:0] c0, d0;
    logic e0;
    L = lat_of(idx);
    lut = core_fn(3'd3, a, b, '0);
    w = 0;
    while (!cmd_ready[idx] && w < 50) begin @(negedge clk); w++; end
    chk({name, "_cmd_ready"}, {255'd0, cmd_ready[idx]}, 256'd1);
    cmd_valid[idx] = 1'b1; cmd_op[idx] = op; cmd_a[idx] = a; cmd_b[idx] = b;
    rsp_ready[idx] = early_ready;
    @(negedge clk);
    cmd_valid[idx] = 1'b0;
    cmd_op[idx] = 3'($urandom);
    rand256(r); cmd_a[idx] = r;
    rand256(r); cmd_b[idx] = r;
    cyc = 1; sel_ok = 1'b1; ready_ok = 1'b1;
    while (cyc <= 64) begin
      if (core_sel[idx] !== exp_sel(op, cyc, L)) sel_ok = 1'b0;
      if (cmd_ready[idx] !== 1'b0) ready_ok = 1'b0;
      if (op == 3'd5 && cyc == L + 1) begin
        chk({name, "_exec2_core_a"}, core_a[idx], lut);
        chk({name, "_exec2_core_b"}, core_b[idx], {a[255:128], b[255:128]});
      end
      if (rsp_valid[idx]) break;
      @(negedge clk);
      cyc++;
    end
    chk({name, "_latency"}, 256'(cyc), 256'(exp_lat(op, L)));
    chk({name, "_core_sel_seq"}, {255'd0, sel_ok}, 256'd1);
    chk({name, "_cmd_ready_low"}, {255'd0, ready_ok}, 256'd1);
    chk({name, "_rsp_err"}, {255'd0, rsp_err[idx]}, {255'd0, exp[256]});
    chk({name, "_rsp_c"}, {128'd0, rsp_c[idx]}, {128'd0, exp[255:128]});
    chk({name, "_rsp_d"}, {128'd0, rsp_d[idx]}, {128'd0, exp[127:0]});
    if (!early_ready && hold > 0) begin
      c0 = rsp_c[idx]; d0 = rsp_d[idx]; e0 = rsp_err[idx];
      stable_ok = 1'b1;
      for (int h = 0; h < hold; h++) begin
        @(negedge clk);
        if (rsp_valid[idx] !== 1'b1 || rsp_c[idx] !== c0 || rsp_d[idx] !== d0 ||
            rsp_err[idx] !== e0 || cmd_ready[idx] !== 1'b0 || core_sel[idx] !== 3'd0)
          stable_ok = 1'b0;
      end
      chk({name, "_stall_stable"}, {255'd0, stable_ok}, 256'd1);
    end
    rsp_ready[idx] = 1'b1;
    @(negedge clk);
    rsp_ready[idx] = 1'b0;
    chk({name, "_rsp_valid_drop"}, {255'd0, rsp_valid[idx]}, 256'd0);
    chk({name, "_ready_again"}, {255'd0, cmd_ready[idx]}, 256'd1);
  endtask

  typedef struct {
    string        name;
    logic [2:0]   op;
    logic [255:0] a;
    logic [255:0] b;
    int           hold;
    logic         exp_err;
    logic [127:0] exp_c;
    logic [127:0] exp_d;
  } vec_t;

  vec_t tbl[7];

  initial begin
    logic [255:0] ra, rb;
    logic [2:0]   rop;
    bit           seen;

    tbl[0] = '{"xor",     3'd2, 256'h00F0, 256'h000F, 0, 1'b0, 128'd0, 128'hFF};
    tbl[1] = '{"sqr",     3'd1, 256'd0,    256'h3,    0, 1'b0, 128'd0, 128'h5};
    tbl[2] = '{"mask",    3'd4, 256'd0,    256'd0,    2, 1'b0, 128'd0,
               128'h0000_0000_0000_0000_FFFF_FFFF_FFFF_FFFF};
    tbl[3] = '{"muladd",  3'd5, 256'h3, {128'h1, 128'h3}, 0, 1'b0, 128'd0, 128'h4};
    tbl[4] = '{"illegal7", 3'd7, 256'hDEAD, 256'hBEEF, 5, 1'b1, 128'd0, 128'd0};
    tbl[5] = '{"illegal0", 3'd0, 256'h1234, 256'h5678, 0, 1'b1, 128'd0, 128'd0};
    tbl[6] = '{"lut",     3'd3, 256'h5,    256'h3,    1, 1'b0, 128'd0, 128'hF};

    for (int i = 0; i < 3; i++) begin
      rst_n[i] = 1'b0; cmd_valid[i] = 1'b0; rsp_ready[i] = 1'b0;
      cmd_op[i] = 3'd0; cmd_a[i] = '0; cmd_b[i] = '0;
    end
    repeat (3) @(negedge clk);
    chk("reset_cmd_ready", {255'd0, cmd_ready[0]}, 256'd0);
    chk("reset_core_sel", {253'd0, core_sel[0]}, 256'd0);
    chk("reset_core_a", core_a[0], 256'd0);
    chk("reset_core_b", core_b[0], 256'd0);
    chk("reset_rsp_valid", {255'd0, rsp_valid[0]}, 256'd0);
    chk("reset_rsp_cd", {rsp_c[0], rsp_d[0]}, 256'd0);
    chk("reset_rsp_err", {255'd0, rsp_err[0]}, 256'd0);
    for (int i = 0; i < 3; i++) rst_n[i] = 1'b1;
    @(negedge clk);
    chk("release_cmd_ready", {255'd0, cmd_ready[0]}, 256'd1);

    for (int i = 0; i < 7; i++)
      run_cmd(0, tbl[i].op, tbl[i].a, tbl[i].b,
              {tbl[i].exp_err, tbl[i].exp_c, tbl[i].exp_d}, tbl[i].hold, 1'b0, tbl[i].name);

    run_cmd(1, 3'd1, 256'd0, 256'h3, {1'b0, 128'd0, 128'h5}, 0, 1'b0, "sqr_lat3");
    run_cmd(1, 3'd5, 256'h3, {128'h1, 128'h3}, {1'b0, 128'd0, 128'h4}, 2, 1'b0, "muladd_lat3");

    // Reset mid-EXEC1 on the CORE_LAT=4 instance.
    @(negedge clk);
    cmd_valid[2] = 1'b1; cmd_op[2] = 3'd2; cmd_a[2] = 256'hAA; cmd_b[2] = 256'h55;
    @(negedge clk);
    cmd_valid[2] = 1'b0;
    chk("abort_sel_cycle1", {253'd0, core_sel[2]}, 256'd2);
    @(posedge clk);
    #2 rst_n[2] = 1'b0;
    #1;
    chk("abort_sel_zero", {253'd0, core_sel[2]}, 256'd0);
    chk("abort_core_a_zero", core_a[2], 256'd0);
    chk("abort_rsp_valid", {255'd0, rsp_valid[2]}, 256'd0);
    chk("abort_cmd_ready", {255'd0, cmd_ready[2]}, 256'd0);
    @(negedge clk); @(negedge clk);
    rst_n[2] = 1'b1;
    @(negedge clk);
    chk("abort_ready_after", {255'd0, cmd_ready[2]}, 256'd1);
    seen = 1'b0;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      if (rsp_valid[2] !== 1'b0) seen = 1'b1;
    end
    chk("abort_no_response", {255'd0, seen}, 256'd0);
    run_cmd(2, 3'd1, 256'd0, 256'h7, {1'b0, 128'd0, 128'h15}, 0, 1'b0, "post_abort_sqr");

    // Randomized commands against the reference model.
    for (int n = 0; n < 60; n++) begin
      rop = 3'($urandom_range(0, 7));
      rand256(ra); rand256(rb);
      run_cmd(n % 3, rop, ra, rb, ref_rsp(rop, ra, rb), int'($urandom_range(0, 3)),
              1'($urandom_range(0, 1)), "rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
